ee_poll_monitor: RTL and testbench

- Downstream completion stage for the JEDEC page-write sequencer of the W29EE011-class DIP32 bottomhalf.
- Starts once the sequencer has released #WE after the last payload byte.
- Issues timed DUT read cycles on the osc domain and detects end of the internal program cycle by toggle-bit (DQ6) or DATA# (DQ7) polling.
- Reports done / timeout / verify-error to the microcontroller status register, so software no longer has to wait a fixed delay.

---
 rtl/ee_poll_monitor.sv | 171 +++++++++++++++++
 tb/tb_ee_poll_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ee_poll_monitor.sv
// ee_poll_monitor: completion stage after a JEDEC page write on the DIP32 bottomhalf.
// It issues timed #CE/#OE read cycles to the target device and polls DQ6 (toggle bit)
// or DQ7 (DATA#, plus a full-byte confirm read) until the internal program cycle ends.
// It reports done / timeout / verify_err as sticky flags.
// DQ is never driven here; the enclosing module keeps the bus tri-stated while busy.
module ee_poll_monitor #(
  parameter int RD_CYCLES      = 3,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 240000
) (
  input  logic        osc,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        mode,
  input  logic [7:0]  expected,
  input  logic [7:0]  dut_dq,
  output logic        dut_ce_n,
  output logic        dut_oe_n,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        verify_err,
  output logic [7:0]  last_dq,
  output logic [15:0] poll_count
);

  localparam logic [17:0] TMO_LOAD = 18'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RD_LAST  = 8'(RD_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OE_LOW,
    GAP,
    EVAL,
    COMPLETE
  } state_t;

  state_t      state;
  logic [17:0] tmo_cnt;
  logic [7:0]  phase;
  logic        first_read;
  logic        confirming;
  logic        prev_dq6;
  logic        err_pending;

  // Poll sequencer. Priority while busy is abort, then completion, then timeout, then the read loop.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dut_ce_n    <= 1'b1;
      dut_oe_n    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      verify_err  <= 1'b0;
      last_dq     <= '0;
      poll_count  <= '0;
      tmo_cnt     <= '0;
      phase       <= '0;
      first_read  <= 1'b0;
      confirming  <= 1'b0;
      prev_dq6    <= 1'b0;
      err_pending <= 1'b0;
    end else if (state == IDLE) begin
      if (start && !abort) begin
        done        <= 1'b0;
        timeout     <= 1'b0;
        verify_err  <= 1'b0;
        poll_count  <= '0;
        tmo_cnt     <= TMO_LOAD;
        busy        <= 1'b1;
        dut_ce_n    <= 1'b0;
        dut_oe_n    <= 1'b1;
        phase       <= '0;
        first_read  <= 1'b1;
        confirming  <= 1'b0;
        prev_dq6    <= 1'b0;
        err_pending <= 1'b0;
        state       <= SETUP;
      end
    end else begin
      if (tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 18'd1;
      end
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        dut_ce_n <= 1'b1;
        dut_oe_n <= 1'b1;
      end else if (state == COMPLETE) begin
        done       <= 1'b1;
        verify_err <= err_pending;
        busy       <= 1'b0;
        dut_ce_n   <= 1'b1;
        dut_oe_n   <= 1'b1;
        state      <= IDLE;
      end else if (tmo_cnt == '0) begin
        timeout  <= 1'b1;
        busy     <= 1'b0;
        dut_ce_n <= 1'b1;
        dut_oe_n <= 1'b1;
        state    <= IDLE;
      end else begin
        case (state)
          SETUP: begin
            dut_oe_n <= 1'b0;
            phase    <= '0;
            state    <= OE_LOW;
          end
          OE_LOW: begin
            if (phase == RD_LAST) begin
              last_dq  <= dut_dq;
              dut_oe_n <= 1'b1;
              phase    <= '0;
              state    <= GAP;
              if (poll_count != 16'hFFFF) begin
                poll_count <= poll_count + 16'd1;
              end
            end else begin
              phase <= phase + 8'd1;
            end
          end
          GAP: begin
            if (phase == GAP_LAST) begin
              phase <= '0;
              state <= EVAL;
            end else begin
              phase <= phase + 8'd1;
            end
          end
          EVAL: begin
            if (confirming) begin
              err_pending <= (last_dq != expected);
              state       <= COMPLETE;
            end else if (!mode) begin
              if (first_read) begin
                first_read <= 1'b0;
                prev_dq6   <= last_dq[6];
                dut_oe_n   <= 1'b0;
                state      <= OE_LOW;
              end else if (last_dq[6] == prev_dq6) begin
                state <= COMPLETE;
              end else begin
                prev_dq6 <= last_dq[6];
                dut_oe_n <= 1'b0;
                state    <= OE_LOW;
              end
            end else if (last_dq[7] != expected[7]) begin
              dut_oe_n <= 1'b0;
              state    <= OE_LOW;
            end else begin
              confirming <= 1'b1;
              dut_oe_n   <= 1'b0;
              state      <= OE_LOW;
            end
          end
          default: begin
            busy     <= 1'b0;
            dut_ce_n <= 1'b1;
            dut_oe_n <= 1'b1;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ee_poll_monitor.sv
// tb_ee_poll_monitor: drives ee_poll_monitor with directed and random poll runs.
// The reference model predicts every output from the edge offset since start.
module tb_ee_poll_monitor;

  localparam int RD   = 3;
  localparam int GAP  = 2;
  localparam int SLOT = RD + GAP + 1;
  localparam int TMO  = 100;

  logic        osc = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        mode;
  logic [7:0]  expected;
  logic [7:0]  dut_dq;
  logic        dut_ce_n;
  logic        dut_oe_n;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        verify_err;
  logic [7:0]  last_dq;
  logic [15:0] poll_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] seq [64];

  // reference model state
  logic        m_busy, m_done, m_timeout, m_verr, m_ce_n, m_oe_n;
  logic [7:0]  m_last_dq;
  logic [15:0] m_poll;
  int          m_t, m_reads;
  bit          m_finishing, m_confirm, m_prev6, m_err_pending;

  ee_poll_monitor #(
    .RD_CYCLES(RD),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .osc(osc),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .mode(mode),
    .expected(expected),
    .dut_dq(dut_dq),
    .dut_ce_n(dut_ce_n),
    .dut_oe_n(dut_oe_n),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .verify_err(verify_err),
    .last_dq(last_dq),
    .poll_count(poll_count)
  );

  // 24 MHz-style free-running clock
  always #5 osc = ~osc;

  task automatic modelReset();
    m_busy = 0; m_done = 0; m_timeout = 0; m_verr = 0; m_ce_n = 1; m_oe_n = 1;
    m_last_dq = 8'h00; m_poll = 16'h0000; m_t = 0; m_reads = 0;
    m_finishing = 0; m_confirm = 0; m_prev6 = 0; m_err_pending = 0;
  endtask

  // Decide after a finished read whether another read is needed.
  task automatic modelEvaluate(output bit go_on);
    go_on = 1'b1;
    if (!mode) begin
      if (m_reads == 1) begin
        m_prev6 = m_last_dq[6];
      end else if (m_last_dq[6] == m_prev6) begin
        go_on = 1'b0;
      end else begin
        m_prev6 = m_last_dq[6];
      end
    end else begin
      if (m_confirm) begin
        m_err_pending = (m_last_dq != expected);
        go_on = 1'b0;
      end else if (m_last_dq[7] == expected[7]) begin
        m_confirm = 1'b1;
      end
    end
  endtask

  // Every read occupies SLOT edges starting at offset 1; the sample edge is RD edges in.
  task automatic modelStep();
    bit go_on;
    if (!m_busy) begin
      if (start && !abort) begin
        m_busy = 1; m_ce_n = 0; m_oe_n = 1;
        m_done = 0; m_timeout = 0; m_verr = 0; m_poll = 16'h0000;
        m_t = 0; m_reads = 0; m_finishing = 0; m_confirm = 0;
        m_err_pending = 0; m_prev6 = 0;
      end
    end else begin
      m_t = m_t + 1;
      if (abort) begin
        m_busy = 0; m_ce_n = 1; m_oe_n = 1;
      end else if (m_finishing) begin
        m_done = 1; m_verr = m_err_pending; m_busy = 0; m_ce_n = 1; m_oe_n = 1;
      end else if (m_t == TMO) begin
        m_timeout = 1; m_busy = 0; m_ce_n = 1; m_oe_n = 1;
      end else if ((m_t - 1) % SLOT == 0) begin
        go_on = 1'b1;
        if (m_t > 1) modelEvaluate(go_on);
        if (go_on) m_oe_n = 0;
        else m_finishing = 1;
      end else if ((m_t - 1) % SLOT == RD) begin
        m_last_dq = dut_dq;
        m_reads = m_reads + 1;
        if (m_poll != 16'hFFFF) m_poll = m_poll + 16'd1;
        m_oe_n = 1;
      end
    end
  endtask

  // model advances on every clock edge and resets asynchronously with the DUT
  always @(posedge osc or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, got, want);
    end
  endtask

  // One clock: drive inputs at negedge, let the edge happen, compare against the model.
  task automatic applyStimulus(input logic s, input logic a);
    @(negedge osc);
    start = s;
    abort = a;
    if (m_busy && !m_finishing && (m_t % SLOT) == RD)
      dut_dq = seq[(m_reads > 63) ? 63 : m_reads];
    else
      dut_dq = 8'($urandom);
    @(posedge osc);
    #2;
    checkOutput("cycle",
                {2'b00, busy, done, timeout, verify_err, dut_ce_n, dut_oe_n, last_dq, poll_count},
                {2'b00, m_busy, m_done, m_timeout, m_verr, m_ce_n, m_oe_n, m_last_dq, m_poll});
  endtask

  task automatic runUntilIdle(input int start_at, output int lat, output int oe_low);
    lat = 0;
    oe_low = 0;
    while ((busy || m_busy) && lat < 400) begin
      applyStimulus(lat == start_at, 1'b0);
      lat++;
      if (!dut_oe_n) oe_low++;
    end
    checkOutput("run_bound", {31'b0, busy}, 32'd0);
  endtask

  task automatic fillSeq(input logic [7:0] v);
    for (int i = 0; i < 64; i++) seq[i] = v;
  endtask

  task automatic buildRandomSeq();
    int nt;
    int nm;
    logic [7:0] v;
    if (!mode) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      nt = ($urandom_range(0, 5) == 0) ? 40 : int'($urandom_range(0, 5));
      for (int i = 0; i < 64; i++) begin
        v = 8'($urandom);
        v[6] = b ^ (((i < nt) ? i : nt) % 2 == 1);
        seq[i] = v;
      end
    end else begin
      nm = ($urandom_range(0, 5) == 0) ? 40 : int'($urandom_range(0, 4));
      for (int i = 0; i < 64; i++) begin
        v = 8'($urandom);
        if (i < nm) v[7] = ~expected[7];
        else if (i == nm) v[7] = expected[7];
        else if (i == nm + 1 && $urandom_range(0, 2) != 0) v = expected;
        seq[i] = v;
      end
    end
  endtask

  initial begin
    int lat;
    int oe_low;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode = 1'b0;
    expected = 8'h00;
    dut_dq = 8'h00;
    fillSeq(8'h00);

    // reset state
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("rst_ce_n", {31'b0, dut_ce_n}, 32'd1);
    checkOutput("rst_oe_n", {31'b0, dut_oe_n}, 32'd1);
    checkOutput("rst_flags", {28'b0, busy, done, timeout, verify_err}, 32'd0);
    checkOutput("rst_poll", {16'b0, poll_count}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // mode 0: DQ6 0,1,0,0
    mode = 1'b0;
    fillSeq(8'h00);
    seq[1] = 8'h40;
    applyStimulus(1'b1, 1'b0);
    runUntilIdle(-1, lat, oe_low);
    checkOutput("t1_latency", lat, 32'd26);
    checkOutput("t1_oe_low", oe_low, 32'd12);
    checkOutput("t1_done", {31'b0, done}, 32'd1);
    checkOutput("t1_timeout", {31'b0, timeout}, 32'd0);
    checkOutput("t1_poll", {16'b0, poll_count}, 32'd4);

    // abort in idle leaves sticky flags; start+abort together does not start
    applyStimulus(1'b0, 1'b1);
    checkOutput("idle_abort_done", {31'b0, done}, 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("start_abort_poll", {16'b0, poll_count}, 32'd4);

    // mode 1: expected A5, reads 25,25,A5 + confirm A5
    mode = 1'b1;
    expected = 8'hA5;
    fillSeq(8'hA5);
    seq[0] = 8'h25;
    seq[1] = 8'h25;
    applyStimulus(1'b1, 1'b0);
    runUntilIdle(-1, lat, oe_low);
    checkOutput("t2_latency", lat, 32'd26);
    checkOutput("t2_done", {31'b0, done}, 32'd1);
    checkOutput("t2_verr", {31'b0, verify_err}, 32'd0);
    checkOutput("t2_poll", {16'b0, poll_count}, 32'd4);
    checkOutput("t2_last_dq", {24'b0, last_dq}, 32'hA5);

    // mode 1: expected 80, DQ7 high, confirm 81
    expected = 8'h80;
    fillSeq(8'h81);
    applyStimulus(1'b1, 1'b0);
    runUntilIdle(-1, lat, oe_low);
    checkOutput("t3_latency", lat, 32'd14);
    checkOutput("t3_done", {31'b0, done}, 32'd1);
    checkOutput("t3_verr", {31'b0, verify_err}, 32'd1);
    checkOutput("t3_last_dq", {24'b0, last_dq}, 32'h81);

    // mode 0: DQ6 toggles forever -> timeout at edge 100
    mode = 1'b0;
    for (int i = 0; i < 64; i++) seq[i] = (i % 2 == 1) ? 8'h40 : 8'h00;
    applyStimulus(1'b1, 1'b0);
    runUntilIdle(-1, lat, oe_low);
    checkOutput("t4_latency", lat, 32'd100);
    checkOutput("t4_timeout", {31'b0, timeout}, 32'd1);
    checkOutput("t4_done", {31'b0, done}, 32'd0);
    checkOutput("t4_pins", {30'b0, dut_oe_n, dut_ce_n}, 32'd3);
    checkOutput("t4_poll", {16'b0, poll_count}, 32'd16);

    // abort during OE_LOW of read 2, then a clean restart
    fillSeq(8'h00);
    seq[1] = 8'h40;
    applyStimulus(1'b1, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b0);
    checkOutput("t5_pre_oe_n", {31'b0, dut_oe_n}, 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t5_busy", {31'b0, busy}, 32'd0);
    checkOutput("t5_pins", {30'b0, dut_oe_n, dut_ce_n}, 32'd3);
    checkOutput("t5_done", {31'b0, done}, 32'd0);
    checkOutput("t5_poll", {16'b0, poll_count}, 32'd1);
    fillSeq(8'h00);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_restart_poll", {16'b0, poll_count}, 32'd0);
    checkOutput("t5_restart_busy", {31'b0, busy}, 32'd1);
    runUntilIdle(-1, lat, oe_low);
    checkOutput("t5_latency", lat, 32'd14);
    checkOutput("t5_done2", {31'b0, done}, 32'd1);

    // start pulse while busy is ignored
    applyStimulus(1'b1, 1'b0);
    runUntilIdle(4, lat, oe_low);
    checkOutput("t6_latency", lat, 32'd14);
    checkOutput("t6_poll", {16'b0, poll_count}, 32'd2);

    // async reset in the middle of read 2
    fillSeq(8'h3C);
    seq[1] = 8'h7C;
    applyStimulus(1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0);
    checkOutput("t7_pre_oe_n", {31'b0, dut_oe_n}, 32'd0);
    checkOutput("t7_pre_last", {24'b0, last_dq}, 32'h3C);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t7_pins", {30'b0, dut_oe_n, dut_ce_n}, 32'd3);
    checkOutput("t7_flags", {28'b0, busy, done, timeout, verify_err}, 32'd0);
    checkOutput("t7_poll", {16'b0, poll_count}, 32'd0);
    checkOutput("t7_last", {24'b0, last_dq}, 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // random runs against the model
    for (int r = 0; r < 80; r++) begin
      int n;
      mode = 1'($urandom_range(0, 1));
      expected = 8'($urandom);
      buildRandomSeq();
      applyStimulus(1'b1, ($urandom_range(0, 9) == 0));
      n = 0;
      while ((busy || m_busy) && n < 400) begin
        applyStimulus(($urandom_range(0, 11) == 0), ($urandom_range(0, 59) == 0));
        n++;
      end
      checkOutput("rand_idle", {31'b0, busy}, 32'd0);
      applyStimulus(1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
